can_tx_frame_loader: RTL and testbench
======================================

// Module: can_tx_frame_loader
// PURPOSE
//  Pops 128-bit frame words from the Tx FIFO and unpacks them into CAN header and data fields.
//  Presents each frame to the bit-level transmitter over a valid/ack handshake.
//  Retries on arbitration loss or bus error, and drops the frame after MAX_RETRY failed attempts.
//  Sits between the Tx FIFO read port and the CAN bit-stream transmitter.
// PARAMETERS
//  DATA_WIDTH  128  FIFO word width; layout below; must be 128
//  MAX_RETRY   3    retransmissions allowed after the first attempt; 0 = single-shot
//  CNT_WIDTH   16   width of the o_tx_ok_count success counter
// PORTS
//  i_sys_clk        in   1    system clock; all logic on rising edge
//  i_reset_n        in   1    synchronous active-low reset
//  i_fifo_empty     in   1    Tx FIFO empty flag
//  i_fifo_r_data    in   128  Tx FIFO read data; registered, valid the cycle after o_fifo_r_en
//  o_fifo_r_en      out  1    Tx FIFO read strobe; one-cycle pulse per pop
//  o_frame_valid    out  1    fields below are stable and offered to the transmitter
//  o_id             out  29   identifier; standard frames use [10:0], [28:11]=0
//  o_ide            out  1    extended-identifier flag
//  o_rtr            out  1    remote-frame flag
//  o_dlc            out  4    DLC exactly as stored
//  o_len            out  4    payload byte count = min(DLC,8), and 0 when RTR=1
//  o_data           out  64   payload; byte0 in [7:0]
//  i_tx_ack         in   1    transmitter accepted the frame (SOF started)
//  i_tx_done        in   1    one-cycle pulse: frame sent and ACKed
//  i_tx_arb_lost    in   1    one-cycle pulse: arbitration lost
//  i_tx_error       in   1    one-cycle pulse: bus/ACK error on this frame
//  i_abort_req      in   1    host request to drop the current frame
//  o_tx_ok          out  1    one-cycle pulse: frame completed successfully
//  o_tx_abort       out  1    one-cycle pulse: frame dropped (retries exhausted or abort)
//  o_busy           out  1    high in every state except IDLE
//  o_tx_ok_count    out  CNT_WIDTH  successful frames since reset; wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  FIFO word layout: [28:0] id, [29] ide, [30] rtr, [34:31] dlc, [63:35] reserved (ignored), [127:64] data.
//  Reset (i_reset_n=0 at an edge): state=IDLE, retry_cnt=0, all outputs 0, o_tx_ok_count=0.
//    A frame held or popped is lost; no pulse is generated for it.
//  FSM states (Moore outputs):
//   IDLE  : if !i_fifo_empty -> POP.
//   POP   : o_fifo_r_en=1 for exactly one cycle -> CAPT. No pop is ever issued while i_fifo_empty=1.
//   CAPT  : register all fields from i_fifo_r_data; clear retry_cnt -> PRESENT.
//   PRESENT: o_frame_valid=1, fields held constant.
//     i_tx_ack -> WAIT. i_abort_req (priority over ack) -> pulse o_tx_abort, go to IDLE.
//   WAIT  : o_frame_valid=0, fields still held.
//     Event priority, highest first: i_tx_error, i_tx_arb_lost, i_tx_done, i_abort_req.
//     error/arb_lost: if retry_cnt<MAX_RETRY, then retry_cnt++ and go to PRESENT (same frame, no pop);
//       otherwise pulse o_tx_abort and go to IDLE.
//     done: pulse o_tx_ok, o_tx_ok_count++, go to IDLE.
//     abort in WAIT: latched; takes effect at the next error/arb_lost/done.
//       If that event is done, it still counts as o_tx_ok; otherwise the frame is dropped with no retry.
//  Latency: IDLE with !empty -> o_fifo_r_en in cycle +1 -> o_frame_valid in cycle +3.
//  Back-to-back: after o_tx_ok, the next pop occurs the cycle after IDLE is re-entered.
//    Minimum 4 cycles from the done pulse to the next o_frame_valid.
//  Handshake inputs (ack/done/arb_lost/error) arriving in IDLE/POP/CAPT, or ack arriving in WAIT: ignored.
//  DLC 9..15: o_dlc=raw value, o_len=8. RTR=1: o_len=0, but o_data still holds the word's bits.
// TESTING
//  1. Reset, FIFO holds id=0x123, ide=0, dlc=2, data=0xBEEF -> one r_en pulse, valid 3 cycles later,
//     o_len=2, o_data=0xBEEF; ack then done -> o_tx_ok=1, count=1.
//  2. MAX_RETRY=3; arb_lost after each of 3 acks, then done -> 4 presentations, 1 pop, o_tx_ok, no abort.
//  3. MAX_RETRY=3; error after 4 acks -> o_tx_abort on the 4th error, count unchanged; next frame then popped.
//  4. dlc=12 -> o_len=8; rtr=1 with dlc=4 -> o_len=0.
//  5. i_fifo_empty=1 for 100 cycles -> o_fifo_r_en never asserted, o_busy=0.
//  6. Reset asserted in WAIT -> next cycle all outputs 0, IDLE; abort in PRESENT -> o_tx_abort, no o_tx_ok.

Source files
------------

// File: rtl/can_tx_frame_loader.sv
// can_tx_frame_loader: pops packed CAN frames from the Tx FIFO, unpacks them
// into header/data fields and offers them to the bit-stream transmitter,
// retrying on arbitration loss or bus error up to MAX_RETRY times.
module can_tx_frame_loader #(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset_n,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_r_data,
  output logic                  o_fifo_r_en,
  output logic                  o_frame_valid,
  output logic [28:0]           o_id,
  output logic                  o_ide,
  output logic                  o_rtr,
  output logic [3:0]            o_dlc,
  output logic [3:0]            o_len,
  output logic [63:0]           o_data,
  input  logic                  i_tx_ack,
  input  logic                  i_tx_done,
  input  logic                  i_tx_arb_lost,
  input  logic                  i_tx_error,
  input  logic                  i_abort_req,
  output logic                  o_tx_ok,
  output logic                  o_tx_abort,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_tx_ok_count
);

  // Retry counter must hold 0..MAX_RETRY; keep at least one bit for single-shot.
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_CAPT,
    ST_PRESENT,
    ST_WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] retry_cnt;
  logic          abort_pend;
  logic          ok_nxt;
  logic          abort_nxt;
  logic          retry_inc;
  logic          retry_ok;
  logic          fail_evt;
  logic [3:0]    cap_dlc;
  logic          cap_rtr;
  logic [3:0]    cap_len;
  logic          unused_reserved;

  assign retry_ok        = (retry_cnt < RW'(MAX_RETRY));
  assign fail_evt        = i_tx_error | i_tx_arb_lost;
  assign unused_reserved = ^i_fifo_r_data[63:35];

  // Moore outputs decoded straight from the state register.
  assign o_fifo_r_en   = (state == ST_POP);
  assign o_frame_valid = (state == ST_PRESENT);
  assign o_busy        = (state != ST_IDLE);

  // Payload length: clamp DLC to 8 bytes, and remote frames carry no payload.
  always_comb begin
    cap_dlc = i_fifo_r_data[34:31];
    cap_rtr = i_fifo_r_data[30];
    cap_len = cap_dlc;
    if (cap_rtr) begin
      cap_len = 4'd0;
    end else if (cap_dlc > 4'd8) begin
      cap_len = 4'd8;
    end
  end

  // State register.
  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the one-shot completion/abort/retry decisions.
  always_comb begin
    state_nxt = state;
    ok_nxt    = 1'b0;
    abort_nxt = 1'b0;
    retry_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!i_fifo_empty) begin
          state_nxt = ST_POP;
        end
      end
      ST_POP: begin
        state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (i_abort_req) begin
          state_nxt = ST_IDLE;
          abort_nxt = 1'b1;
        end else if (i_tx_ack) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fail_evt) begin
          if (abort_pend || !retry_ok) begin
            state_nxt = ST_IDLE;
            abort_nxt = 1'b1;
          end else begin
            state_nxt = ST_PRESENT;
            retry_inc = 1'b1;
          end
        end else if (i_tx_done) begin
          state_nxt = ST_IDLE;
          ok_nxt    = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame field capture, retry bookkeeping, pending abort and result pulses.
  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      o_id          <= '0;
      o_ide         <= 1'b0;
      o_rtr         <= 1'b0;
      o_dlc         <= '0;
      o_len         <= '0;
      o_data        <= '0;
      o_tx_ok       <= 1'b0;
      o_tx_abort    <= 1'b0;
      o_tx_ok_count <= '0;
      retry_cnt     <= '0;
      abort_pend    <= 1'b0;
    end else begin
      o_tx_ok    <= ok_nxt;
      o_tx_abort <= abort_nxt;
      if (ok_nxt) begin
        o_tx_ok_count <= o_tx_ok_count + CNT_WIDTH'(1);
      end
      if (state == ST_CAPT) begin
        o_id       <= i_fifo_r_data[28:0];
        o_ide      <= i_fifo_r_data[29];
        o_rtr      <= cap_rtr;
        o_dlc      <= cap_dlc;
        o_len      <= cap_len;
        o_data     <= i_fifo_r_data[127:64];
        retry_cnt  <= '0;
        abort_pend <= 1'b0;
      end
      if (retry_inc) begin
        retry_cnt <= retry_cnt + RW'(1);
      end
      if (state == ST_WAIT) begin
        if (state_nxt == ST_IDLE) begin
          abort_pend <= 1'b0;
        end else if (state_nxt == ST_WAIT && i_abort_req) begin
          abort_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_can_tx_frame_loader.sv
// tb_can_tx_frame_loader: drives can_tx_frame_loader from a FIFO model and a
// scoreboard of expected frames, one task per scenario.
module tb_can_tx_frame_loader;

  localparam int MAX_RETRY = 3;
  localparam int CNT_WIDTH = 16;

  logic                 i_sys_clk = 1'b0;
  logic                 i_reset_n;
  logic                 i_fifo_empty;
  logic [127:0]         i_fifo_r_data = '0;
  logic                 o_fifo_r_en;
  logic                 o_frame_valid;
  logic [28:0]          o_id;
  logic                 o_ide;
  logic                 o_rtr;
  logic [3:0]           o_dlc;
  logic [3:0]           o_len;
  logic [63:0]          o_data;
  logic                 i_tx_ack;
  logic                 i_tx_done;
  logic                 i_tx_arb_lost;
  logic                 i_tx_error;
  logic                 i_abort_req;
  logic                 o_tx_ok;
  logic                 o_tx_abort;
  logic                 o_busy;
  logic [CNT_WIDTH-1:0] o_tx_ok_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ok   = 0;

  // FIFO model: storage written only by the stimulus, read pointer only by the pop process.
  logic [127:0] fifo_mem [0:63];
  int wr_ptr        = 0;
  int rd_ptr        = 0;
  int pop_cnt       = 0;
  int pop_empty_cnt = 0;
  assign i_fifo_empty = (wr_ptr == rd_ptr);

  // Scoreboard of expected {id, ide, rtr, dlc, len, data}.
  logic [102:0] sb_q [$];
  logic [102:0] exp_f;
  logic [102:0] obs_f;
  assign obs_f = {o_id, o_ide, o_rtr, o_dlc, o_len, o_data};

  // Event counters sampled once per cycle.
  int  present_cnt = 0;
  int  ok_cnt      = 0;
  int  abort_cnt   = 0;
  logic valid_q    = 1'b0;

  localparam int EV_ACK = 0, EV_DONE = 1, EV_ARB = 2, EV_ERR = 3, EV_ABORT = 4;

  can_tx_frame_loader #(
    .DATA_WIDTH(128),
    .MAX_RETRY (MAX_RETRY),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .i_sys_clk    (i_sys_clk),
    .i_reset_n    (i_reset_n),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_r_data(i_fifo_r_data),
    .o_fifo_r_en  (o_fifo_r_en),
    .o_frame_valid(o_frame_valid),
    .o_id         (o_id),
    .o_ide        (o_ide),
    .o_rtr        (o_rtr),
    .o_dlc        (o_dlc),
    .o_len        (o_len),
    .o_data       (o_data),
    .i_tx_ack     (i_tx_ack),
    .i_tx_done    (i_tx_done),
    .i_tx_arb_lost(i_tx_arb_lost),
    .i_tx_error   (i_tx_error),
    .i_abort_req  (i_abort_req),
    .o_tx_ok      (o_tx_ok),
    .o_tx_abort   (o_tx_abort),
    .o_busy       (o_busy),
    .o_tx_ok_count(o_tx_ok_count)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  // Registered-read FIFO: data appears the cycle after the read strobe.
  always @(posedge i_sys_clk) begin
    if (o_fifo_r_en) begin
      pop_cnt++;
      if (wr_ptr == rd_ptr) begin
        pop_empty_cnt++;
      end else begin
        i_fifo_r_data <= fifo_mem[rd_ptr % 64];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // Count presentations and result pulses.
  always @(posedge i_sys_clk) begin
    if (o_frame_valid && !valid_q) present_cnt++;
    valid_q = o_frame_valid;
    if (o_tx_ok) ok_cnt++;
    if (o_tx_abort) abort_cnt++;
  end

  function automatic logic [127:0] make_word(input logic [28:0] id, input logic ide,
                                             input logic rtr, input logic [3:0] dlc,
                                             input logic [63:0] data);
    return {data, 29'h1ABCDE01, dlc, rtr, ide, id};
  endfunction

  task automatic load_frame(input logic [28:0] id, input logic ide, input logic rtr,
                            input logic [3:0] dlc, input logic [63:0] data);
    logic [3:0] len;
    len = rtr ? 4'd0 : ((dlc > 4'd8) ? 4'd8 : dlc);
    fifo_mem[wr_ptr % 64] = make_word(id, ide, rtr, dlc, data);
    wr_ptr = wr_ptr + 1;
    sb_q.push_back({id, ide, rtr, dlc, len, data});
  endtask

  task automatic pulse_in(input int k);
    case (k)
      EV_ACK:  i_tx_ack      = 1'b1;
      EV_DONE: i_tx_done     = 1'b1;
      EV_ARB:  i_tx_arb_lost = 1'b1;
      EV_ERR:  i_tx_error    = 1'b1;
      default: i_abort_req   = 1'b1;
    endcase
    @(negedge i_sys_clk);
    i_tx_ack      = 1'b0;
    i_tx_done     = 1'b0;
    i_tx_arb_lost = 1'b0;
    i_tx_error    = 1'b0;
    i_abort_req   = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_frame_valid && lat < 50) begin
      @(negedge i_sys_clk);
      lat++;
    end
    if (!o_frame_valid) lat = -1;
  endtask

  task automatic test_reset;
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_sys_clk);
    n_checks++;
    if ({o_fifo_r_en, o_frame_valid, obs_f, o_tx_ok, o_tx_abort, o_busy, o_tx_ok_count} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got busy=%b valid=%b count=%0d, expected all zero",
               o_busy, o_frame_valid, o_tx_ok_count);
    end
    i_reset_n = 1'b1;
    @(negedge i_sys_clk);
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got busy=%b, expected 0", o_busy);
    end
  endtask

  task automatic test_basic;
    load_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'hBEEF);
    @(negedge i_sys_clk);
    n_checks++;
    if (o_fifo_r_en !== 1'b1) begin
      n_fail++; $display("[TB] FAIL basic_ren: got %b, expected 1", o_fifo_r_en);
    end
    @(negedge i_sys_clk);
    n_checks++;
    if ({o_fifo_r_en, o_frame_valid} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL basic_capt: got ren/valid=%b%b, expected 00", o_fifo_r_en, o_frame_valid);
    end
    @(negedge i_sys_clk);
    exp_f = sb_q.pop_front();
    n_checks++;
    if (o_frame_valid !== 1'b1 || obs_f !== exp_f) begin
      n_fail++; $display("[TB] FAIL basic_frame: got valid=%b fields=%h, expected 1 %h", o_frame_valid, obs_f, exp_f);
    end
    pulse_in(EV_ACK);
    n_checks++;
    if ({o_frame_valid, o_busy} !== 2'b01) begin
      n_fail++; $display("[TB] FAIL basic_wait: got valid/busy=%b%b, expected 01", o_frame_valid, o_busy);
    end
    pulse_in(EV_DONE);
    exp_ok++;
    n_checks++;
    if (o_tx_ok !== 1'b1 || o_tx_ok_count !== CNT_WIDTH'(exp_ok) || o_busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL basic_ok: got ok=%b count=%0d busy=%b, expected 1 %0d 0", o_tx_ok, o_tx_ok_count, o_busy, exp_ok);
    end
    @(negedge i_sys_clk);
    n_checks++;
    if (o_tx_ok !== 1'b0) begin
      n_fail++; $display("[TB] FAIL basic_ok_pulse: got %b, expected 0", o_tx_ok);
    end
  endtask

  task automatic test_retry;
    int lat, p0, q0, a0, k0;
    p0 = present_cnt; q0 = pop_cnt; a0 = abort_cnt; k0 = ok_cnt;
    load_frame(29'h055, 1'b0, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF);
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    n_checks++;
    if (lat !== 3 || obs_f !== exp_f) begin
      n_fail++; $display("[TB] FAIL retry_first: got lat=%0d fields=%h, expected 3 %h", lat, obs_f, exp_f);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_in(EV_ACK);
      pulse_in(EV_ARB);
      n_checks++;
      if ({o_frame_valid, o_tx_abort} !== 2'b10 || obs_f !== exp_f) begin
        n_fail++; $display("[TB] FAIL retry_represent%0d: got valid/abort=%b%b, expected 10", i, o_frame_valid, o_tx_abort);
      end
    end
    pulse_in(EV_ACK);
    pulse_in(EV_DONE);
    exp_ok++;
    n_checks++;
    if (o_tx_ok !== 1'b1 || o_tx_ok_count !== CNT_WIDTH'(exp_ok)) begin
      n_fail++; $display("[TB] FAIL retry_ok: got ok=%b count=%0d, expected 1 %0d", o_tx_ok, o_tx_ok_count, exp_ok);
    end
    repeat (2) @(negedge i_sys_clk);
    n_checks++;
    if (present_cnt - p0 !== 4 || pop_cnt - q0 !== 1 || abort_cnt - a0 !== 0 || ok_cnt - k0 !== 1) begin
      n_fail++; $display("[TB] FAIL retry_counts: got present=%0d pops=%0d aborts=%0d oks=%0d, expected 4 1 0 1",
                         present_cnt - p0, pop_cnt - q0, abort_cnt - a0, ok_cnt - k0);
    end
  endtask

  task automatic test_error_abort;
    int lat, p0, q0;
    p0 = present_cnt; q0 = pop_cnt;
    load_frame(29'h7FF, 1'b0, 1'b0, 4'd1, 64'hA5);
    load_frame(29'h001, 1'b0, 1'b0, 4'd3, 64'h00C0FFEE);
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++; $display("[TB] FAIL err_frameA: got %h, expected %h", obs_f, exp_f);
    end
    for (int i = 0; i < 4; i++) begin
      pulse_in(EV_ACK);
      pulse_in(EV_ERR);
      n_checks++;
      if (i < 3) begin
        if ({o_frame_valid, o_tx_abort} !== 2'b10) begin
          n_fail++; $display("[TB] FAIL err_retry%0d: got valid/abort=%b%b, expected 10", i, o_frame_valid, o_tx_abort);
        end
      end else begin
        if ({o_frame_valid, o_tx_abort, o_tx_ok} !== 3'b010 || o_tx_ok_count !== CNT_WIDTH'(exp_ok)) begin
          n_fail++; $display("[TB] FAIL err_drop: got valid/abort/ok=%b%b%b count=%0d, expected 010 %0d",
                             o_frame_valid, o_tx_abort, o_tx_ok, o_tx_ok_count, exp_ok);
        end
      end
    end
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    n_checks++;
    if (lat !== 3 || obs_f !== exp_f) begin
      n_fail++; $display("[TB] FAIL err_frameB: got lat=%0d fields=%h, expected 3 %h", lat, obs_f, exp_f);
    end
    pulse_in(EV_ACK);
    pulse_in(EV_DONE);
    exp_ok++;
    @(negedge i_sys_clk);
    n_checks++;
    if (present_cnt - p0 !== 5 || pop_cnt - q0 !== 2 || o_tx_ok_count !== CNT_WIDTH'(exp_ok)) begin
      n_fail++; $display("[TB] FAIL err_counts: got present=%0d pops=%0d count=%0d, expected 5 2 %0d",
                         present_cnt - p0, pop_cnt - q0, o_tx_ok_count, exp_ok);
    end
  endtask

  task automatic test_dlc;
    int lat;
    load_frame(29'h1ABC_DEF1, 1'b1, 1'b0, 4'd12, 64'h1122_3344_5566_7788);
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    n_checks++;
    if (obs_f !== exp_f || o_len !== 4'd8 || o_dlc !== 4'd12) begin
      n_fail++; $display("[TB] FAIL dlc12: got len=%0d dlc=%0d fields=%h, expected 8 12 %h", o_len, o_dlc, obs_f, exp_f);
    end
    pulse_in(EV_ACK);
    pulse_in(EV_DONE);
    exp_ok++;
    load_frame(29'h2AA, 1'b0, 1'b1, 4'd4, 64'hDEAD_BEEF);
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    n_checks++;
    if (obs_f !== exp_f || o_len !== 4'd0 || o_data !== 64'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL rtr_len: got len=%0d data=%h, expected 0 deadbeef", o_len, o_data);
    end
    pulse_in(EV_ACK);
    pulse_in(EV_DONE);
    exp_ok++;
  endtask

  task automatic test_back_to_back;
    int lat, q0;
    q0 = pop_cnt;
    load_frame(29'h010, 1'b0, 1'b0, 4'd5, 64'h55_4433_2211);
    load_frame(29'h020, 1'b0, 1'b0, 4'd6, 64'hAA_BBCC_DDEE_FF00);
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++; $display("[TB] FAIL b2b_first: got %h, expected %h", obs_f, exp_f);
    end
    pulse_in(EV_ACK);
    pulse_in(EV_DONE);
    exp_ok++;
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    n_checks++;
    if (lat !== 3 || obs_f !== exp_f) begin
      n_fail++; $display("[TB] FAIL b2b_second: got lat=%0d fields=%h, expected 3 %h", lat, obs_f, exp_f);
    end
    pulse_in(EV_ACK);
    pulse_in(EV_DONE);
    exp_ok++;
    n_checks++;
    if (pop_cnt - q0 !== 2 || o_tx_ok_count !== CNT_WIDTH'(exp_ok)) begin
      n_fail++; $display("[TB] FAIL b2b_counts: got pops=%0d count=%0d, expected 2 %0d", pop_cnt - q0, o_tx_ok_count, exp_ok);
    end
  endtask

  task automatic test_abort_latched;
    int lat, p0;
    p0 = present_cnt;
    load_frame(29'h0F0, 1'b0, 1'b0, 4'd2, 64'h3C3C);
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    pulse_in(EV_ACK);
    pulse_in(EV_ABORT);
    n_checks++;
    if ({o_frame_valid, o_tx_abort, o_busy} !== 3'b001) begin
      n_fail++; $display("[TB] FAIL latch_hold: got valid/abort/busy=%b%b%b, expected 001", o_frame_valid, o_tx_abort, o_busy);
    end
    pulse_in(EV_ARB);
    n_checks++;
    if ({o_frame_valid, o_tx_abort, o_busy} !== 3'b010) begin
      n_fail++; $display("[TB] FAIL latch_drop: got valid/abort/busy=%b%b%b, expected 010", o_frame_valid, o_tx_abort, o_busy);
    end
    repeat (2) @(negedge i_sys_clk);
    n_checks++;
    if (present_cnt - p0 !== 1) begin
      n_fail++; $display("[TB] FAIL latch_noretry: got presentations=%0d, expected 1", present_cnt - p0);
    end
    load_frame(29'h0F1, 1'b0, 1'b0, 4'd1, 64'h7E);
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    pulse_in(EV_ACK);
    pulse_in(EV_ABORT);
    pulse_in(EV_DONE);
    exp_ok++;
    n_checks++;
    if ({o_tx_ok, o_tx_abort} !== 2'b10 || o_tx_ok_count !== CNT_WIDTH'(exp_ok)) begin
      n_fail++; $display("[TB] FAIL latch_done: got ok/abort=%b%b count=%0d, expected 10 %0d", o_tx_ok, o_tx_abort, o_tx_ok_count, exp_ok);
    end
  endtask

  task automatic test_empty;
    int q0;
    q0 = pop_cnt;
    repeat (2) @(negedge i_sys_clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge i_sys_clk);
      n_checks++;
      if ({o_fifo_r_en, o_busy} !== 2'b00) begin
        n_fail++; $display("[TB] FAIL empty_cycle%0d: got ren/busy=%b%b, expected 00", i, o_fifo_r_en, o_busy);
      end
    end
    n_checks++;
    if (pop_cnt - q0 !== 0) begin
      n_fail++; $display("[TB] FAIL empty_pops: got %0d, expected 0", pop_cnt - q0);
    end
  endtask

  task automatic test_reset_abort;
    int lat, k0;
    load_frame(29'h333, 1'b0, 1'b0, 4'd7, 64'h0706_0504_0302_0100);
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    pulse_in(EV_ACK);
    i_reset_n = 1'b0;
    @(negedge i_sys_clk);
    n_checks++;
    if ({o_fifo_r_en, o_frame_valid, obs_f, o_tx_ok, o_tx_abort, o_busy, o_tx_ok_count} !== '0) begin
      n_fail++; $display("[TB] FAIL wait_reset: got busy=%b count=%0d id=%h, expected all zero", o_busy, o_tx_ok_count, o_id);
    end
    i_reset_n = 1'b1;
    exp_ok = 0;
    k0 = ok_cnt;
    repeat (5) @(negedge i_sys_clk);
    n_checks++;
    if (o_busy !== 1'b0 || ok_cnt - k0 !== 0 || o_tx_ok_count !== CNT_WIDTH'(exp_ok)) begin
      n_fail++; $display("[TB] FAIL wait_reset_idle: got busy=%b oks=%0d count=%0d, expected 0 0 0", o_busy, ok_cnt - k0, o_tx_ok_count);
    end
    load_frame(29'h444, 1'b0, 1'b0, 4'd0, 64'h0);
    wait_valid(lat);
    exp_f = sb_q.pop_front();
    n_checks++;
    if (lat !== 3 || obs_f !== exp_f) begin
      n_fail++; $display("[TB] FAIL present_frame: got lat=%0d fields=%h, expected 3 %h", lat, obs_f, exp_f);
    end
    i_tx_ack = 1'b1;
    pulse_in(EV_ABORT);
    n_checks++;
    if ({o_tx_abort, o_tx_ok, o_busy} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL present_abort: got abort/ok/busy=%b%b%b, expected 100", o_tx_abort, o_tx_ok, o_busy);
    end
    repeat (3) @(negedge i_sys_clk);
    n_checks++;
    if (ok_cnt - k0 !== 0 || pop_empty_cnt !== 0) begin
      n_fail++; $display("[TB] FAIL present_abort_nook: got oks=%0d empty_pops=%0d, expected 0 0", ok_cnt - k0, pop_empty_cnt);
    end
  endtask

  initial begin
    i_reset_n     = 1'b0;
    i_tx_ack      = 1'b0;
    i_tx_done     = 1'b0;
    i_tx_arb_lost = 1'b0;
    i_tx_error    = 1'b0;
    i_abort_req   = 1'b0;
    test_reset();
    test_basic();
    test_retry();
    test_error_abort();
    test_dlc();
    test_back_to_back();
    test_abort_latched();
    test_empty();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
